// File: rtl/gcn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gcn_pkg
//  Description : Shared types and widths for the GCN combination stage.
//                Holds the FSM state encoding and the data/address widths
//                used by gcn_aggregate_argmax and gcn_argmax.
//  Revision    : 1.0 - initial release
// ============================================================================
package gcn_pkg;

   localparam int NUM_OF_NODES      = 6;
   localparam int WEIGHT_COLS       = 3;
   localparam int DOT_PROD_WIDTH    = 16;
   localparam int AGG_WIDTH         = DOT_PROD_WIDTH + 3;
   localparam int COO_NUM_OF_COLS   = 6;
   localparam int COO_BW            = 3;
   localparam int MAX_ADDRESS_WIDTH = 2;
   localparam int ROW_AW            = $clog2(NUM_OF_NODES);

   // One counter walks rows, edges and argmax nodes, so it must cover the
   // longer of the two sequences.
   localparam int MAX_STEPS = (NUM_OF_NODES > COO_NUM_OF_COLS) ? NUM_OF_NODES : COO_NUM_OF_COLS;
   localparam int CNT_W     = $clog2(MAX_STEPS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      EDGE   = 3'd2,
      ARGMAX = 3'd3,
      DONE   = 3'd4
   } state_t;

endpackage : gcn_pkg
`default_nettype wire

// File: rtl/gcn_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : gcn_argmax
//  Description : Combinational unsigned argmax over NUM_COLS packed values.
//                Ties resolve to the lowest column index.
//  Ports       : i_vals  - NUM_COLS values, column 0 in the LSBs
//                o_idx   - index of the largest value
//  Revision    : 1.0 - initial release
// ============================================================================
module gcn_argmax
   import gcn_pkg::*;
#(
   parameter int NUM_COLS = WEIGHT_COLS,
   parameter int VAL_W    = AGG_WIDTH,
   parameter int IDX_W    = MAX_ADDRESS_WIDTH
) (
   input  logic [NUM_COLS*VAL_W-1:0] i_vals,
   output logic [IDX_W-1:0]          o_idx
);

   logic [VAL_W-1:0] w_best_val;
   logic [IDX_W-1:0] w_best_idx;

   // Strict greater-than keeps the earlier column on equal values.
   always_comb begin
      w_best_val = i_vals[VAL_W-1:0];
      w_best_idx = '0;
      for (int c = 1; c < NUM_COLS; c++) begin
         if (i_vals[c*VAL_W +: VAL_W] > w_best_val) begin
            w_best_val = i_vals[c*VAL_W +: VAL_W];
            w_best_idx = IDX_W'(c);
         end
      end
   end

   assign o_idx = w_best_idx;

endmodule : gcn_argmax
`default_nettype wire

// File: rtl/gcn_aggregate_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : gcn_aggregate_argmax
//  Description : GCN combination stage. Loads the product matrix row by row,
//                aggregates each node with its neighbours over the COO edge
//                list (plus self-loop) and emits the per-node argmax column.
//  Ports       : clk             - rising-edge clock
//                reset           - asynchronous active-low reset
//                start           - begin a pass (sampled in IDLE only)
//                fm_wm_row_addr  - product row address (0 outside LOAD)
//                fm_wm_row_in    - product row data, column 0 in LSBs
//                coo_address     - edge index (0 outside EDGE)
//                coo_in          - {dst, src}, 1-based node indices
//                busy            - high in LOAD / EDGE / ARGMAX
//                done            - high in DONE
//                max_addi_answer - per-node argmax, node n at [n*MAW +: MAW]
//  Revision    : 1.0 - initial release
// ============================================================================
module gcn_aggregate_argmax
   import gcn_pkg::*;
(
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      start,
   output logic [ROW_AW-1:0]                         fm_wm_row_addr,
   input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]     fm_wm_row_in,
   output logic [COO_BW-1:0]                         coo_address,
   input  logic [2*COO_BW-1:0]                       coo_in,
   output logic                                      busy,
   output logic                                      done,
   output logic [NUM_OF_NODES*MAX_ADDRESS_WIDTH-1:0] max_addi_answer
);

   localparam logic [CNT_W-1:0]  c_LAST_ROW  = CNT_W'(NUM_OF_NODES - 1);
   localparam logic [CNT_W-1:0]  c_LAST_EDGE = CNT_W'(COO_NUM_OF_COLS - 1);
   localparam logic [COO_BW-1:0] c_NODES     = COO_BW'(NUM_OF_NODES);
   localparam logic [COO_BW-1:0] c_ONE       = COO_BW'(1);

   state_t                         r_state;
   logic [CNT_W-1:0]               r_cnt;
   logic                           r_busy;
   logic                           r_done;
   logic [DOT_PROD_WIDTH-1:0]      r_row_buf [NUM_OF_NODES][WEIGHT_COLS];
   logic [AGG_WIDTH-1:0]           r_acc     [NUM_OF_NODES][WEIGHT_COLS];
   logic [MAX_ADDRESS_WIDTH-1:0]   r_ans     [NUM_OF_NODES];

   logic [ROW_AW-1:0]                  w_node;
   logic [COO_BW-1:0]                  w_src;
   logic [COO_BW-1:0]                  w_dst;
   logic [ROW_AW-1:0]                  w_src_idx;
   logic [ROW_AW-1:0]                  w_dst_idx;
   logic                               w_edge_ok;
   logic [WEIGHT_COLS*AGG_WIDTH-1:0]   w_acc_flat;
   logic [MAX_ADDRESS_WIDTH-1:0]       w_max_idx;

   assign w_node = ROW_AW'(r_cnt);
   assign w_src  = coo_in[COO_BW-1:0];
   assign w_dst  = coo_in[2*COO_BW-1:COO_BW];

   // COO indices are 1-based; convert to row-buffer indices.
   assign w_src_idx = ROW_AW'(w_src - c_ONE);
   assign w_dst_idx = ROW_AW'(w_dst - c_ONE);

   // Self edges are skipped because the self-loop is folded in during LOAD.
   assign w_edge_ok = (w_src != '0) && (w_dst != '0) &&
                      (w_src <= c_NODES) && (w_dst <= c_NODES) &&
                      (w_src != w_dst);

   generate
      for (genvar c = 0; c < WEIGHT_COLS; c++) begin : g_acc_mux
         assign w_acc_flat[c*AGG_WIDTH +: AGG_WIDTH] = r_acc[w_node][c];
      end
   endgenerate

   gcn_argmax #(
      .NUM_COLS (WEIGHT_COLS),
      .VAL_W    (AGG_WIDTH),
      .IDX_W    (MAX_ADDRESS_WIDTH)
   ) u_argmax (
      .i_vals (w_acc_flat),
      .o_idx  (w_max_idx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int n = 0; n < NUM_OF_NODES; n++) begin
            r_ans[n] <= '0;
            for (int c = 0; c < WEIGHT_COLS; c++) begin
               r_row_buf[n][c] <= '0;
               r_acc[n][c]     <= '0;
            end
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= LOAD;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end

            LOAD: begin
               for (int c = 0; c < WEIGHT_COLS; c++) begin
                  r_row_buf[w_node][c] <= fm_wm_row_in[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
                  r_acc[w_node][c]     <= AGG_WIDTH'(fm_wm_row_in[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]);
               end
               if (r_cnt == c_LAST_ROW) begin
                  r_state <= EDGE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            EDGE: begin
               // Undirected edge: both endpoints accumulate in the same cycle.
               // w_edge_ok guarantees the two targets differ.
               if (w_edge_ok) begin
                  for (int c = 0; c < WEIGHT_COLS; c++) begin
                     r_acc[w_src_idx][c] <= r_acc[w_src_idx][c] + AGG_WIDTH'(r_row_buf[w_dst_idx][c]);
                     r_acc[w_dst_idx][c] <= r_acc[w_dst_idx][c] + AGG_WIDTH'(r_row_buf[w_src_idx][c]);
                  end
               end
               if (r_cnt == c_LAST_EDGE) begin
                  r_state <= ARGMAX;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ARGMAX: begin
               r_ans[w_node] <= w_max_idx;
               if (r_cnt == c_LAST_ROW) begin
                  r_state <= DONE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            DONE: begin
               if (!start) begin
                  r_state <= IDLE;
                  r_done  <= 1'b0;
               end
            end

            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign fm_wm_row_addr = (r_state == LOAD) ? w_node : '0;
   assign coo_address    = (r_state == EDGE) ? COO_BW'(r_cnt) : '0;
   assign busy           = r_busy;
   assign done           = r_done;

   generate
      for (genvar n = 0; n < NUM_OF_NODES; n++) begin : g_ans_flat
         assign max_addi_answer[n*MAX_ADDRESS_WIDTH +: MAX_ADDRESS_WIDTH] = r_ans[n];
      end
   endgenerate

endmodule : gcn_aggregate_argmax
`default_nettype wire

// File: tb/tb_gcn_aggregate_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcn_aggregate_argmax
//  Description : Directed self-checking bench for gcn_aggregate_argmax.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcn_aggregate_argmax;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  fm_wm_row_addr;
   logic [47:0] fm_wm_row_in;
   logic [2:0]  coo_address;
   logic [5:0]  coo_in;
   logic        busy;
   logic        done;
   logic [11:0] max_addi_answer;

   logic [47:0] rows [6];
   logic [5:0]  coo  [6];

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign fm_wm_row_in = rows[fm_wm_row_addr];
   assign coo_in       = coo[coo_address];

   gcn_aggregate_argmax dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .fm_wm_row_addr  (fm_wm_row_addr),
      .fm_wm_row_in    (fm_wm_row_in),
      .coo_address     (coo_address),
      .coo_in          (coo_in),
      .busy            (busy),
      .done            (done),
      .max_addi_answer (max_addi_answer)
   );

   function automatic logic [47:0] mk_row(input int a, input int b, input int c);
      logic [15:0] x, y, z;
      x = 16'(a); y = 16'(b); z = 16'(c);
      return {z, y, x};
   endfunction

   function automatic logic [5:0] mk_edge(input int src, input int dst);
      logic [2:0] s, d;
      s = 3'(src); d = 3'(dst);
      return {d, s};
   endfunction

   // Drives one pass; lat = edge count (start-sampling edge = 1) until done.
   task automatic run_pass(input bit pulse_mode, output int lat);
      lat   = 0;
      start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (pulse_mode) begin
            if (k == 1 || k == 6) start = 1'b0;
            if (k == 5) start = 1'b1;
         end
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic leave_done();
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (max_addi_answer !== 12'h000) begin miscompares++; $display("FAIL reset_ans: got %h expected 000", max_addi_answer); end
      vectors++; if (fm_wm_row_addr !== 3'd0) begin miscompares++; $display("FAIL reset_row_addr: got %0d expected 0", fm_wm_row_addr); end
      vectors++; if (coo_address !== 3'd0) begin miscompares++; $display("FAIL reset_coo_addr: got %0d expected 0", coo_address); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_no_edges();
      logic [2:0] exp_row, exp_coo;
      logic       exp_busy, exp_done;
      for (int r = 0; r < 6; r++) begin
         rows[r] = mk_row(r + 1, 2 * (r + 1), 3 * (r + 1));
         coo[r]  = 6'd0;
      end
      start = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         @(posedge clk); #1;
         exp_row  = (k <= 6) ? 3'(k - 1) : 3'd0;
         exp_coo  = (k >= 7 && k <= 12) ? 3'(k - 7) : 3'd0;
         exp_busy = (k <= 18);
         exp_done = (k == 19);
         vectors++; if (fm_wm_row_addr !== exp_row) begin miscompares++; $display("FAIL seq_row_addr k=%0d: got %0d expected %0d", k, fm_wm_row_addr, exp_row); end
         vectors++; if (coo_address !== exp_coo) begin miscompares++; $display("FAIL seq_coo_addr k=%0d: got %0d expected %0d", k, coo_address, exp_coo); end
         vectors++; if (busy !== exp_busy) begin miscompares++; $display("FAIL seq_busy k=%0d: got %b expected %b", k, busy, exp_busy); end
         vectors++; if (done !== exp_done) begin miscompares++; $display("FAIL seq_done k=%0d: got %b expected %b", k, done, exp_done); end
      end
      vectors++; if (max_addi_answer !== 12'hAAA) begin miscompares++; $display("FAIL no_edges_ans: got %h expected aaa", max_addi_answer); end
      // start still high: must stay in DONE
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL hold_done: got %b expected 1", done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_busy: got %b expected 0", busy); end
      leave_done();
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL exit_done: got %b expected 0", done); end
      vectors++; if (max_addi_answer !== 12'hAAA) begin miscompares++; $display("FAIL ans_held_idle: got %h expected aaa", max_addi_answer); end
   endtask

   task automatic test_edge_pair();
      int lat;
      for (int r = 0; r < 6; r++) begin
         rows[r] = 48'd0;
         coo[r]  = 6'd0;
      end
      rows[0] = mk_row(5, 1, 1);
      rows[1] = mk_row(0, 9, 0);
      coo[0]  = mk_edge(1, 2);
      run_pass(1'b0, lat);
      vectors++; if (lat !== 19) begin miscompares++; $display("FAIL pair_latency: got %0d expected 19", lat); end
      vectors++; if (max_addi_answer !== 12'h005) begin miscompares++; $display("FAIL pair_ans: got %h expected 005", max_addi_answer); end
      leave_done();
   endtask

   task automatic test_tie();
      int lat;
      for (int r = 0; r < 6; r++) begin
         rows[r] = mk_row(7, 7, 3);
         coo[r]  = 6'd0;
      end
      coo[0] = mk_edge(3, 3);
      run_pass(1'b0, lat);
      vectors++; if (lat !== 19) begin miscompares++; $display("FAIL tie_latency: got %0d expected 19", lat); end
      vectors++; if (max_addi_answer !== 12'h000) begin miscompares++; $display("FAIL tie_ans: got %h expected 000", max_addi_answer); end
      leave_done();
   endtask

   task automatic test_out_of_range();
      int lat;
      for (int r = 0; r < 6; r++) begin
         rows[r] = mk_row(r + 1, 2 * (r + 1), 3 * (r + 1));
         coo[r]  = 6'd0;
      end
      coo[0] = mk_edge(0, 7);
      coo[1] = mk_edge(7, 1);
      run_pass(1'b0, lat);
      vectors++; if (lat !== 19) begin miscompares++; $display("FAIL oor_latency: got %0d expected 19", lat); end
      vectors++; if (max_addi_answer !== 12'hAAA) begin miscompares++; $display("FAIL oor_ans: got %h expected aaa", max_addi_answer); end
      leave_done();
   endtask

   task automatic test_reset_mid();
      int lat;
      for (int r = 0; r < 6; r++) begin
         rows[r] = 48'd0;
         coo[r]  = 6'd0;
      end
      rows[0] = mk_row(5, 1, 1);
      rows[1] = mk_row(0, 9, 0);
      coo[0]  = mk_edge(1, 2);
      start = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      vectors++; if (coo_address !== 3'd2) begin miscompares++; $display("FAIL mid_in_edge: got %0d expected 2", coo_address); end
      start = 1'b0;
      reset = 1'b0;
      #2;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_done: got %b expected 0", done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b expected 0", busy); end
      vectors++; if (max_addi_answer !== 12'h000) begin miscompares++; $display("FAIL mid_ans: got %h expected 000", max_addi_answer); end
      vectors++; if (coo_address !== 3'd0) begin miscompares++; $display("FAIL mid_coo_addr: got %0d expected 0", coo_address); end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_idle_busy: got %b expected 0", busy); end
      run_pass(1'b0, lat);
      vectors++; if (lat !== 19) begin miscompares++; $display("FAIL restart_latency: got %0d expected 19", lat); end
      vectors++; if (max_addi_answer !== 12'h005) begin miscompares++; $display("FAIL restart_ans: got %h expected 005", max_addi_answer); end
      leave_done();
   endtask

   // acc0 = [7*65535, 65534, 0]; a 16-bit accumulator would wrap col0 to
   // 65529 and flip node 0 to column 1.
   task automatic test_star();
      int lat;
      for (int r = 0; r < 6; r++) rows[r] = mk_row(65535, 0, 0);
      rows[0] = mk_row(65535, 65534, 0);
      coo[0] = mk_edge(1, 2);
      coo[1] = mk_edge(1, 3);
      coo[2] = mk_edge(1, 4);
      coo[3] = mk_edge(1, 5);
      coo[4] = mk_edge(1, 6);
      coo[5] = mk_edge(2, 1);
      run_pass(1'b1, lat);
      vectors++; if (lat !== 19) begin miscompares++; $display("FAIL star_latency: got %0d expected 19", lat); end
      vectors++; if (max_addi_answer !== 12'h000) begin miscompares++; $display("FAIL star_ans: got %h expected 000", max_addi_answer); end
      // start already low, so DONE lasts one cycle
      @(posedge clk); #1;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL star_exit: got %b expected 0", done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL star_idle_busy: got %b expected 0", busy); end
   endtask

   initial begin
      for (int r = 0; r < 6; r++) begin
         rows[r] = 48'd0;
         coo[r]  = 6'd0;
      end
      test_reset();
      test_no_edges();
      test_edge_pair();
      test_tie();
      test_out_of_range();
      test_reset_mid();
      test_star();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_gcn_aggregate_argmax
`default_nettype wire
